// File: rtl/spi_device_core_pkg.sv
// rtl/spi_device_core_pkg.sv - shared constants and state encoding for the SPI device core
package spi_device_core_pkg;

  localparam int SPI_DEV_DATA_W = 8;

  typedef enum logic {
    SPI_DEV_IDLE   = 1'b0,
    SPI_DEV_ACTIVE = 1'b1
  } spi_dev_state_e;

endpackage

// File: rtl/spi_dev_sync.sv
// rtl/spi_dev_sync.sv - two-flop synchronizer with registered edge detect on a third stage
module spi_dev_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Resynchronize d; rise/fall pulses line up with the updated level on s3.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1   <= rst_val;
      s2   <= rst_val;
      s3   <= rst_val;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign level = s3;

endmodule

// File: rtl/spi_device_core.sv
// rtl/spi_device_core.sv - SPI target shift engine with TX holding buffer and RX word register
module spi_device_core
  import spi_device_core_pkg::*;
#(
  parameter int DATA_W = SPI_DEV_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              sck_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_dev_state_e    state;
  logic              cfg_cpol;
  logic              cfg_cpha;
  logic              cfg_lsb;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_full;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              mosi_m1;
  logic              mosi_m2;

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_dev_sync u_sck_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .rst_val (cpol),
    .d       (sck_i),
    .level   (sck_lvl),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_dev_sync u_cs_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .rst_val (1'b1),
    .d       (cs_n_i),
    .level   (cs_lvl),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // MOSI only needs its level; two flops keep it a cycle ahead of the SCK edge pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      mosi_m1 <= 1'b0;
      mosi_m2 <= 1'b0;
    end else begin
      mosi_m1 <= mosi_i;
      mosi_m2 <= mosi_m1;
    end
  end

  logic              sck_edge;
  logic              lead_edge;
  logic              trail_edge;
  logic              entry;
  logic              abort;
  logic              run;
  logic              sample;
  logic              shift;
  logic              load;
  logic              tx_wr;
  logic              word_done;
  logic [DATA_W-1:0] rx_next;

  // A leading edge leaves the idle level, a trailing edge returns to it.
  assign sck_edge   = sck_rise | sck_fall;
  assign lead_edge  = sck_edge & (sck_lvl != cfg_cpol);
  assign trail_edge = sck_edge & (sck_lvl == cfg_cpol);

  assign entry  = (state == SPI_DEV_IDLE) && cs_fall && enable;
  assign abort  = (state == SPI_DEV_ACTIVE) && (cs_lvl || cs_rise || !enable);
  assign run    = (state == SPI_DEV_ACTIVE) && !abort;
  assign sample = run && (cfg_cpha ? trail_edge : lead_edge);
  assign shift  = run && (cfg_cpha ? lead_edge : trail_edge);
  // bit_cnt==0 on a shift edge means either the first shift of a cpha=1 word
  // or the shift right after a completed cpha=0 word: both are load points.
  assign load   = (entry && !cfg_cpha) || (shift && (bit_cnt == '0));
  assign tx_wr  = tx_valid && !tx_full;

  assign word_done = sample && (bit_cnt == LAST_BIT);
  assign rx_next   = cfg_lsb ? {mosi_m2, rx_sr[DATA_W-1:1]}
                             : {rx_sr[DATA_W-2:0], mosi_m2};

  // Transfer FSM with TX buffer, shift registers and RX word handshake.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= SPI_DEV_IDLE;
      cfg_cpol    <= cpol;
      cfg_cpha    <= cpha;
      cfg_lsb     <= lsb_first;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      if (tx_wr) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        SPI_DEV_IDLE: begin
          miso_oe <= 1'b0;
          bit_cnt <= '0;
          if (entry) begin
            state <= SPI_DEV_ACTIVE;
            rx_sr <= '0;
          end else begin
            // Mode is frozen for the whole CS window once entry happens.
            cfg_cpol <= cpol;
            cfg_cpha <= cpha;
            cfg_lsb  <= lsb_first;
          end
        end
        SPI_DEV_ACTIVE: begin
          if (abort) begin
            state   <= SPI_DEV_IDLE;
            miso_oe <= 1'b0;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
          end else begin
            miso_oe <= 1'b1;
          end
        end
        default: state <= SPI_DEV_IDLE;
      endcase

      if (load) begin
        tx_sr       <= tx_full ? tx_buf : '1;
        tx_underrun <= !tx_full;
        tx_full     <= tx_wr;
      end else if (shift) begin
        tx_sr <= cfg_lsb ? (tx_sr >> 1) : (tx_sr << 1);
      end

      if (sample) begin
        rx_sr   <= rx_next;
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end

      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

  assign miso_o   = miso_oe & (cfg_lsb ? tx_sr[0] : tx_sr[DATA_W-1]);
  assign tx_ready = !tx_full;
  assign busy     = (state == SPI_DEV_ACTIVE);

endmodule

// File: tb/tb_spi_device_core.sv
// tb/tb_spi_device_core.sv - directed self-checking bench for spi_device_core
module tb_spi_device_core;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       enable;
  logic       cpol;
  logic       cpha;
  logic       lsb_first;
  logic       sck_i;
  logic       cs_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int udr_cnt      = 0;
  int ovr_cnt      = 0;
  logic [7:0] rx_q[$];

  spi_device_core #(.DATA_W(8)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .enable      (enable),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb_first   (lsb_first),
    .sck_i       (sck_i),
    .cs_n_i      (cs_n_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  // Pulse counters and log of every RX word handed over.
  always @(negedge clk_in) begin
    if (tx_underrun) udr_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic write_tx(input logic [7:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  // Host side: drive nbits of mo, capture MISO just before each sample edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int b;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = lsb_first ? i : 7 - i;
      if (!cpha) begin
        mosi_i = mo[b];
        cyc(4);
        mi[b] = miso_o;
        sck_i = ~cpol;
        cyc(4);
        sck_i = cpol;
      end else begin
        sck_i  = ~cpol;
        mosi_i = mo[b];
        cyc(4);
        mi[b] = miso_o;
        sck_i = cpol;
        cyc(4);
      end
    end
  endtask

  initial begin
    logic [7:0] mi;
    int base;
    rst = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    sck_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_miso_o", 32'(miso_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Mode 0, MSB first, preloaded 0x3C, host sends 0xA5.
    write_tx(8'h3C);
    check("m0_tx_ready_full", 32'(tx_ready), 32'd0);
    cs_n_i = 1'b0;
    cyc(6);
    check("m0_tx_ready_loaded", 32'(tx_ready), 32'd1);
    check("m0_busy", 32'(busy), 32'd1);
    check("m0_miso_oe", 32'(miso_oe), 32'd1);
    xfer(8'hA5, 8, mi);
    check("m0_miso_word", 32'(mi), 32'h3C);
    cyc(6);
    check("m0_rx_valid", 32'(rx_valid), 32'd1);
    check("m0_rx_data", 32'(rx_data), 32'hA5);
    cs_n_i = 1'b1;
    cyc(6);
    check("m0_busy_end", 32'(busy), 32'd0);
    check("m0_miso_oe_end", 32'(miso_oe), 32'd0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check("m0_rx_pop", 32'(rx_valid), 32'd0);

    // Mode 3, LSB first, tx 0x81, host sends 0x5A.
    cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; sck_i = 1'b1;
    cyc(8);
    write_tx(8'h81);
    rx_ready = 1'b1;
    base = rx_q.size();
    cs_n_i = 1'b0;
    cyc(6);
    xfer(8'h5A, 8, mi);
    check("m3_miso_word", 32'(mi), 32'h81);
    cyc(6);
    check("m3_rx_count", 32'(rx_q.size()), 32'(base + 1));
    check("m3_rx_data", 32'(rx_q[base]), 32'h5A);
    cs_n_i = 1'b1;
    cyc(6);

    // Back-to-back words in one CS window, mode 0.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sck_i = 1'b0;
    cyc(8);
    write_tx(8'h11);
    base = rx_q.size();
    cs_n_i = 1'b0;
    cyc(6);
    check("b2b_tx_ready", 32'(tx_ready), 32'd1);
    write_tx(8'h22);
    xfer(8'hC3, 8, mi);
    check("b2b_miso_w0", 32'(mi), 32'h11);
    xfer(8'h7E, 8, mi);
    check("b2b_miso_w1", 32'(mi), 32'h22);
    cyc(6);
    check("b2b_rx_count", 32'(rx_q.size()), 32'(base + 2));
    check("b2b_rx_w0", 32'(rx_q[base]), 32'hC3);
    check("b2b_rx_w1", 32'(rx_q[base + 1]), 32'h7E);
    cs_n_i = 1'b1;
    cyc(6);

    // Overrun: consumer stalled across two completed words.
    rx_ready = 1'b0;
    base = ovr_cnt;
    cs_n_i = 1'b0;
    cyc(6);
    xfer(8'h01, 8, mi);
    xfer(8'h02, 8, mi);
    cyc(6);
    check("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    check("ovr_rx_data_kept", 32'(rx_data), 32'h01);
    check("ovr_rx_valid", 32'(rx_valid), 32'd1);
    cs_n_i = 1'b1;
    cyc(6);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check("ovr_rx_pop", 32'(rx_valid), 32'd0);

    // CS_N rises after 3 sample edges; next full word still lands.
    rx_ready = 1'b1;
    base = rx_q.size();
    cs_n_i = 1'b0;
    cyc(6);
    xfer(8'hFF, 3, mi);
    cs_n_i = 1'b1;
    cyc(4);
    check("abort_miso_oe", 32'(miso_oe), 32'd0);
    check("abort_miso_o", 32'(miso_o), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    cyc(4);
    check("abort_no_rx", 32'(rx_q.size()), 32'(base));
    cs_n_i = 1'b0;
    cyc(6);
    xfer(8'hF0, 8, mi);
    cyc(6);
    check("abort_next_count", 32'(rx_q.size()), 32'(base + 1));
    check("abort_next_data", 32'(rx_q[base]), 32'hF0);
    cs_n_i = 1'b1;
    cyc(6);

    // Empty TX buffer at CS fall: one underrun at entry, MISO all ones.
    base = udr_cnt;
    cs_n_i = 1'b0;
    cyc(6);
    check("udr_entry_pulse", 32'(udr_cnt - base), 32'd1);
    xfer(8'h00, 8, mi);
    check("udr_miso_word", 32'(mi), 32'hFF);
    cyc(6);
    cs_n_i = 1'b1;
    cyc(6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
